// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-lane data RAM plus MMIO window (IDs, switches, LEDs, counter)
// Ports: i_clk/i_rst, i_req/i_we/i_size/i_uns/i_addr/i_wdata request, i_sw, o_led, o_rvalid/o_rdata/o_err response
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h0010_0000,
  parameter logic [31:0] ID0         = 32'h0126_077C,
  parameter logic [31:0] ID1         = 32'h0119_D87C,
  parameter logic [31:0] ID2         = 32'h070F_B9C7,
  parameter int          SW_W        = 16,
  parameter int          LED_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [1:0]       i_size,
  input  logic             i_uns,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wdata,
  input  logic [SW_W-1:0]  i_sw,
  output logic [LED_W-1:0] o_led,
  output logic             o_rvalid,
  output logic [31:0]      o_rdata,
  output logic             o_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [7:0] r_mem0 [DEPTH_WORDS];
  logic [7:0] r_mem1 [DEPTH_WORDS];
  logic [7:0] r_mem2 [DEPTH_WORDS];
  logic [7:0] r_mem3 [DEPTH_WORDS];

  logic [LED_W-1:0] r_led;
  logic [31:0]      r_cnt;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic [31:0]   w_ram_off;
  logic [31:0]   w_moff;
  logic [AW-1:0] w_idx;
  logic [2:0]    w_sel;
  logic          w_ram_hit;
  logic          w_mmio_in;
  logic          w_mmio_hit;
  logic          w_misalign;
  logic          w_fault;
  logic          w_ram_we;
  logic          w_led_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_ram_rd;
  logic [31:0]   w_mmio_rd;
  logic [31:0]   w_rd;

  assign w_ram_off = i_addr - RAM_BASE;
  assign w_moff    = i_addr - MMIO_BASE;
  assign w_idx     = w_ram_off[AW+1:2];
  assign w_sel     = w_moff[4:2];

  assign w_ram_hit = (i_addr >= RAM_BASE) &&
                     ({1'b0, w_ram_off} < RAM_BYTES);
  assign w_mmio_in = (i_addr >= MMIO_BASE) &&
                     (w_moff < 32'h1C);
  // offset 0x0C is a hole in the window
  assign w_mmio_hit = w_mmio_in && (w_sel != 3'd3);

  always_comb begin
    w_misalign = 1'b0;
    case (i_size)
      2'd1:    w_misalign = i_addr[0];
      2'd2:    w_misalign = |i_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_fault = (i_size == 2'd3) || w_misalign ||
                   (!w_ram_hit && !w_mmio_hit) ||
                   (w_mmio_hit && (i_size != 2'd2)) ||
                   (w_mmio_hit && i_we && (w_sel != 3'd5));

  assign w_ram_we = i_req && !i_rst && i_we &&
                    !w_fault && w_ram_hit;
  assign w_led_we = i_req && i_we && !w_fault &&
                    w_mmio_hit && (w_sel == 3'd5);

  always_comb begin
    w_be = 4'b0000;
    w_wd = i_wdata;
    if (w_ram_we) begin
      case (i_size)
        2'd0: begin
          w_be = 4'b0001 << i_addr[1:0];
          w_wd = {4{i_wdata[7:0]}};
        end
        2'd1: begin
          w_be = 4'b0011 << i_addr[1:0];
          w_wd = {2{i_wdata[15:0]}};
        end
        default: begin
          w_be = 4'b1111;
          w_wd = i_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_be[0]) r_mem0[w_idx] <= w_wd[7:0];
    if (w_be[1]) r_mem1[w_idx] <= w_wd[15:8];
    if (w_be[2]) r_mem2[w_idx] <= w_wd[23:16];
    if (w_be[3]) r_mem3[w_idx] <= w_wd[31:24];
  end

  assign w_word  = {r_mem3[w_idx], r_mem2[w_idx],
                    r_mem1[w_idx], r_mem0[w_idx]};
  assign w_shift = w_word >> {i_addr[1:0], 3'b000};

  always_comb begin
    case (i_size)
      2'd0:
        w_ram_rd = i_uns ? {24'h0, w_shift[7:0]}
                         : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1:
        w_ram_rd = i_uns ? {16'h0, w_shift[15:0]}
                         : {{16{w_shift[15]}}, w_shift[15:0]};
      default:
        w_ram_rd = w_word;
    endcase
  end

  always_comb begin
    w_mmio_rd = 32'h0;
    case (w_sel)
      3'd0:    w_mmio_rd = ID0;
      3'd1:    w_mmio_rd = ID1;
      3'd2:    w_mmio_rd = ID2;
      3'd4:    w_mmio_rd = 32'(i_sw);
      3'd5:    w_mmio_rd = 32'(r_led);
      3'd6:    w_mmio_rd = r_cnt;
      default: w_mmio_rd = 32'h0;
    endcase
  end

  // stores and faults return zero data
  assign w_rd = (w_fault || i_we) ? 32'h0 :
                w_ram_hit ? w_ram_rd : w_mmio_rd;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= 32'h0;
      r_led    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + 32'd1;
      r_rvalid <= i_req;
      if (i_req) begin
        r_rdata <= w_rd;
        r_err   <= w_fault;
      end
      if (w_led_we) r_led <= i_wdata[LED_W-1:0];
    end
  end

  assign o_led    = r_led;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl
// Driver pushes expected responses, negedge monitor pops and compares
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd2;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [15:0] sw = 16'h0;
  logic [15:0] led;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cyc = 0;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        e;
    string       name;
  } exp_t;

  exp_t q[$];

  dmem_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we),
    .i_size(size), .i_uns(uns), .i_addr(addr),
    .i_wdata(wdata), .i_sw(sw), .o_led(led),
    .o_rvalid(rvalid), .o_rdata(rdata), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (rvalid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: rdata=%h err=%b at cyc %0d",
                 rdata, err, cyc);
      end else begin
        e = q.pop_front();
        if (rdata !== e.d || err !== e.e || cyc != e.c) begin
          errors++;
          $display("FAIL %s: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                   e.name, rdata, err, cyc, e.d, e.e, e.c);
        end
      end
    end else if (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no rvalid at cyc %0d", e.name, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input string nm, input logic w,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee);
    exp_t e;
    req = 1'b1; we = w; size = sz; uns = u;
    addr = a; wdata = wd;
    e.c = cyc + 1; e.d = ed; e.e = ee; e.name = nm;
    q.push_back(e);
    tick();
    req = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_cyc = cyc;
    rst = 1'b0;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", 32'(led), 32'h0);

    issue("sw_dead", 1, 2, 0, 32'h8000_0000, 32'hDEAD_BEEF, 0, 0);
    issue("lw_dead", 0, 2, 0, 32'h8000_0000, 0, 32'hDEAD_BEEF, 0);
    issue("sw_w1_clr", 1, 2, 0, 32'h8000_0004, 0, 0, 0);
    issue("sb_80", 1, 0, 0, 32'h8000_0005, 32'h0000_0080, 0, 0);
    issue("lb_s", 0, 0, 0, 32'h8000_0005, 0, 32'hFFFF_FF80, 0);
    issue("lb_u", 0, 0, 1, 32'h8000_0005, 0, 32'h0000_0080, 0);
    issue("lw_w1", 0, 2, 0, 32'h8000_0004, 0, 32'h0000_8000, 0);
    issue("lh_mis", 0, 1, 0, 32'h8000_0003, 0, 0, 1);
    issue("sw_mis", 1, 2, 0, 32'h8000_0002, 32'h1111_1111, 0, 1);
    issue("lw_unch", 0, 2, 0, 32'h8000_0000, 0, 32'hDEAD_BEEF, 0);
    issue("lh_s", 0, 1, 0, 32'h8000_0002, 0, 32'hFFFF_DEAD, 0);
    issue("lh_u", 0, 1, 1, 32'h8000_0000, 0, 32'h0000_BEEF, 0);
    issue("sh_hi", 1, 1, 0, 32'h8000_0002, 32'hFFFF_1234, 0, 0);
    issue("lw_sh", 0, 2, 0, 32'h8000_0000, 0, 32'h1234_BEEF, 0);
    issue("lb_b3", 0, 0, 0, 32'h8000_0003, 0, 32'h0000_0012, 0);
    issue("sz3", 0, 3, 0, 32'h8000_0000, 0, 0, 1);
    issue("sw_top", 1, 2, 0, 32'h8000_0FFC, 32'hCAFE_F00D, 0, 0);
    issue("lw_top", 0, 2, 0, 32'h8000_0FFC, 0, 32'hCAFE_F00D, 0);
    issue("unm_0", 0, 2, 0, 32'h0000_0000, 0, 0, 1);
    issue("unm_end", 0, 2, 0, 32'h8000_1000, 0, 0, 1);

    issue("id0", 0, 2, 0, 32'h0010_0000, 0, 32'h0126_077C, 0);
    issue("id1", 0, 2, 0, 32'h0010_0004, 0, 32'h0119_D87C, 0);
    issue("id2", 0, 2, 0, 32'h0010_0008, 0, 32'h070F_B9C7, 0);
    issue("hole", 0, 2, 0, 32'h0010_000C, 0, 0, 1);
    sw = 16'hA5A5;
    issue("sw_rd", 0, 2, 0, 32'h0010_0010, 0, 32'h0000_A5A5, 0);
    sw = 16'h0F0F;
    issue("led_wr", 1, 2, 0, 32'h0010_0014, 32'h1234_5678, 0, 0);
    chk("led_val", 32'(led), 32'h5678);
    issue("led_rd", 0, 2, 0, 32'h0010_0014, 0, 32'h0000_5678, 0);
    issue("led_sb", 1, 0, 0, 32'h0010_0014, 32'h0000_00AA, 0, 1);
    chk("led_keep", 32'(led), 32'h5678);
    issue("ro_st", 1, 2, 0, 32'h0010_0000, 32'h0, 0, 1);
    issue("mmio_lb", 0, 0, 0, 32'h0010_0010, 0, 0, 1);
    issue("cnt_rd", 0, 2, 0, 32'h0010_0018, 0, 32'(cyc - rst_cyc), 0);
    tick();
    issue("cnt_rd2", 0, 2, 0, 32'h0010_0018, 0, 32'(cyc - rst_cyc), 0);

    issue("led_ff", 1, 2, 0, 32'h0010_0014, 32'h0000_00FF, 0, 0);
    chk("led_ff_val", 32'(led), 32'h00FF);
    repeat (3) tick();
    rst = 1'b1;
    req = 1'b1; we = 1'b0; size = 2'd2;
    addr = 32'h0010_0018;
    tick();
    rst_cyc = cyc;
    rst = 1'b0;
    req = 1'b0;
    chk("rst2_rvalid", 32'(rvalid), 32'h0);
    chk("rst2_led", 32'(led), 32'h0);
    chk("rst2_rdata", rdata, 32'h0);
    issue("cnt_after", 0, 2, 0, 32'h0010_0018, 0, 32'h0, 0);
    issue("lw_keep", 0, 2, 0, 32'h8000_0000, 0, 32'h1234_BEEF, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses missing", q.size());
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
